// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the request unit state encoding.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IFETCH  = 2'd0,
    DACCESS = 2'd1,
    HALTED  = 2'd2
  } ru_state_t;

  function automatic logic addr_match(input word_t a, input word_t b);
    return a == b;
  endfunction

endpackage

// File: rtl/request_unit_if.sv
// Bundle of the request unit's control-unit, cache and coherence signals.
interface request_unit_if;
  import cpu_types_pkg::*;

  logic  dREN, dWEN, datomic, cpu_halt;
  word_t dmemaddr_in, dmemstore_in;
  logic  ihit, dhit, snoop_inv;
  word_t snoop_addr;
  logic  imemREN, dmemREN, dmemWEN, pc_en, halt;
  word_t dmemaddr, dmemstore, sc_result;

  modport ru (
    input  dREN, dWEN, datomic, cpu_halt, dmemaddr_in, dmemstore_in,
    input  ihit, dhit, snoop_inv, snoop_addr,
    output imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore, pc_en, sc_result, halt
  );

  modport tb (
    output dREN, dWEN, datomic, cpu_halt, dmemaddr_in, dmemstore_in,
    output ihit, dhit, snoop_inv, snoop_addr,
    input  imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore, pc_en, sc_result, halt
  );

endinterface

// File: rtl/link_register.sv
// LL/SC reservation: one address plus valid bit, cleared by SC, aliasing stores or snoops.
module link_register
  import cpu_types_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  set_i,
  input  word_t set_addr_i,
  input  logic  clear_i,
  input  logic  snoop_inv_i,
  input  word_t snoop_addr_i,
  output logic  link_valid_o,
  output word_t link_addr_o
);

  logic  valid_q, valid_d;
  word_t addr_q, addr_d;
  logic  snoop_hit;

  assign snoop_hit = snoop_inv_i && addr_match(snoop_addr_i, addr_q);

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (set_i) begin
      // A new LL takes priority unless the same-cycle snoop targets the new address.
      addr_d  = set_addr_i;
      valid_d = !(snoop_inv_i && addr_match(snoop_addr_i, set_addr_i));
    end else if (clear_i || snoop_hit) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign link_valid_o = valid_q;
  assign link_addr_o  = addr_q;

endmodule

// File: rtl/request_unit.sv
// Fetch/memory sequencer: holds data-cache requests, pulses pc_en, resolves SC, latches halt.
module request_unit
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  dREN,
  input  logic  dWEN,
  input  logic  datomic,
  input  logic  cpu_halt,
  input  word_t dmemaddr_in,
  input  word_t dmemstore_in,
  input  logic  ihit,
  input  logic  dhit,
  input  logic  snoop_inv,
  input  word_t snoop_addr,
  output logic  imemREN,
  output logic  dmemREN,
  output logic  dmemWEN,
  output word_t dmemaddr,
  output word_t dmemstore,
  output logic  pc_en,
  output word_t sc_result,
  output logic  halt
);

  ru_state_t state_q, state_d;
  logic      dren_q, dren_d;
  logic      dwen_q, dwen_d;
  logic      atomic_q, atomic_d;
  word_t     addr_q, addr_d;
  word_t     store_q, store_d;

  logic      sc_ok;
  logic      ll_set;
  logic      link_clear;
  logic      link_valid;
  word_t     link_addr;
  logic      sc_doomed;

  // An SC without a matching reservation completes immediately as a failure.
  assign sc_doomed = dWEN && datomic && !(link_valid && addr_match(link_addr, dmemaddr_in));

  always_comb begin
    state_d    = state_q;
    dren_d     = dren_q;
    dwen_d     = dwen_q;
    atomic_d   = atomic_q;
    addr_d     = addr_q;
    store_d    = store_q;
    imemREN    = 1'b0;
    pc_en      = 1'b0;
    sc_ok      = 1'b0;
    ll_set     = 1'b0;
    link_clear = 1'b0;

    case (state_q)
      IFETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          if (cpu_halt) begin
            state_d = HALTED;
          end else if (!(dREN || dWEN) || sc_doomed) begin
            pc_en = 1'b1;
          end else begin
            dren_d   = dREN;
            dwen_d   = dWEN;
            atomic_d = datomic;
            addr_d   = dmemaddr_in;
            store_d  = dmemstore_in;
            state_d  = DACCESS;
          end
        end
      end
      DACCESS: begin
        if (dhit) begin
          pc_en      = 1'b1;
          sc_ok      = dwen_q && atomic_q;
          ll_set     = dren_q && atomic_q;
          link_clear = sc_ok || (dwen_q && !atomic_q && addr_match(addr_q, link_addr));
          dren_d     = 1'b0;
          dwen_d     = 1'b0;
          atomic_d   = 1'b0;
          state_d    = IFETCH;
        end
      end
      HALTED: begin
      end
      default: state_d = IFETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IFETCH;
      dren_q   <= 1'b0;
      dwen_q   <= 1'b0;
      atomic_q <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
    end else begin
      state_q  <= state_d;
      dren_q   <= dren_d;
      dwen_q   <= dwen_d;
      atomic_q <= atomic_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
    end
  end

  link_register u_link (
    .clk_i       (CLK),
    .rst_i       (RST),
    .set_i       (ll_set),
    .set_addr_i  (addr_q),
    .clear_i     (link_clear),
    .snoop_inv_i (snoop_inv),
    .snoop_addr_i(snoop_addr),
    .link_valid_o(link_valid),
    .link_addr_o (link_addr)
  );

  assign dmemREN   = dren_q;
  assign dmemWEN   = dwen_q;
  assign dmemaddr  = addr_q;
  assign dmemstore = store_q;
  assign sc_result = {{(WORD_W-1){1'b0}}, sc_ok};
  assign halt      = (state_q == HALTED);

endmodule
